// File: rtl/rs_correct_buf.sv
// rtl/rs_correct_buf.sv - RS decoder output stage: symbol buffer, error correction, frame statistics
module rs_correct_buf #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          enable,
    input  logic [DW-1:0] x,
    input  logic [7:0]    k,
    input  logic [DW-1:0] dec_error,
    input  logic          dec_valid,
    output logic [DW-1:0] y,
    output logic          y_valid,
    output logic          frame_done,
    output logic [7:0]    err_count,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    typedef enum logic {IDLE, FRAME} state_t;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   level_q, level_d;
    logic [DW-1:0] y_q, y_d;
    logic          y_valid_q;
    logic          frame_done_q;
    logic [7:0]    err_count_q, err_count_d;
    logic          overflow_q, underflow_q;
    state_t        state_q, state_d;
    logic [8:0]    len_q, len_d;
    logic [8:0]    idx_q, idx_d;
    logic [8:0]    acc_q, acc_d;

    logic       full, empty, wr_ok, rd_ok, nz, done;
    logic [8:0] len_now, acc_fin;

    assign full  = (level_q == DEPTH);
    assign empty = (level_q == '0);
    // A read in the same cycle frees the slot the write needs, so a full buffer still accepts.
    assign wr_ok = enable & (~full | dec_valid);
    assign rd_ok = dec_valid & ~empty;
    assign nz    = (dec_error != '0);

    assign level_d = level_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
    assign y_d     = empty ? dec_error : (mem[rp_q] ^ dec_error);

    assign len_now = (k == 8'd0) ? 9'd256 : {1'b0, k};
    assign acc_fin = acc_q + {8'b0, nz};

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wp_q] <= x;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (dec_valid) begin
                    if (len_now == 9'd1) begin
                        done = 1'b1;
                    end else begin
                        state_d = FRAME;
                        len_d   = len_now;
                        idx_d   = 9'd1;
                        acc_d   = {8'b0, nz};
                    end
                end
            end
            FRAME: begin
                if (dec_valid) begin
                    if (idx_q == len_q - 9'd1) begin
                        done    = 1'b1;
                        state_d = IDLE;
                        idx_d   = '0;
                        acc_d   = '0;
                    end else begin
                        idx_d = idx_q + 9'd1;
                        acc_d = acc_fin;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        err_count_d = err_count_q;
        if (done) begin
            err_count_d = acc_fin[8] ? 8'hFF : acc_fin[7:0];
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wp_q         <= '0;
            rp_q         <= '0;
            level_q      <= '0;
            y_q          <= '0;
            y_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_count_q  <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            state_q      <= IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            acc_q        <= '0;
        end else begin
            if (wr_ok) begin
                wp_q <= wp_q + 1'b1;
            end
            if (rd_ok) begin
                rp_q <= rp_q + 1'b1;
            end
            if (dec_valid) begin
                y_q <= y_d;
            end
            if (enable & ~wr_ok) begin
                overflow_q <= 1'b1;
            end
            if (dec_valid & empty) begin
                underflow_q <= 1'b1;
            end
            level_q      <= level_d;
            y_valid_q    <= dec_valid;
            frame_done_q <= done;
            err_count_q  <= err_count_d;
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
        end
    end

    assign y          = y_q;
    assign y_valid    = y_valid_q;
    assign frame_done = frame_done_q;
    assign err_count  = err_count_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_rs_correct_buf.sv
// tb/tb_rs_correct_buf.sv - directed self-checking bench for rs_correct_buf
module tb_rs_correct_buf;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] x = '0;
    logic [7:0] k = 8'd255;
    logic [7:0] dec_error = '0;
    logic       dec_valid = 1'b0;
    logic [7:0] y;
    logic       y_valid;
    logic       frame_done;
    logic [7:0] err_count;
    logic [9:0] level;
    logic       overflow;
    logic       underflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] sym_tab [0:511];
    logic [7:0] err_tab [0:511];

    rs_correct_buf #(.AW(9), .DW(8)) dut (
        .clk(clk), .clrn(clrn), .enable(enable), .x(x), .k(k),
        .dec_error(dec_error), .dec_valid(dec_valid),
        .y(y), .y_valid(y_valid), .frame_done(frame_done),
        .err_count(err_count), .level(level),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        enable = 1'b0;
        dec_valid = 1'b0;
        tick();
        tick();
        clrn = 1'b1;
    endtask

    task automatic clr_err();
        for (int i = 0; i < 512; i++) err_tab[i] = 8'h00;
    endtask

    task automatic do_writes(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            enable = 1'b1;
            x = 8'(base + i);
            sym_tab[i] = x;
            tick();
        end
        enable = 1'b0;
    endtask

    task automatic do_reads(input int n, input int len, input string tag);
        for (int i = 0; i < n; i++) begin
            dec_valid = 1'b1;
            dec_error = err_tab[i];
            tick();
            check($sformatf("%s_y%0d", tag, i), {24'b0, y}, {24'b0, sym_tab[i] ^ err_tab[i]});
            check($sformatf("%s_yv%0d", tag, i), {31'b0, y_valid}, 32'd1);
            check($sformatf("%s_fd%0d", tag, i), {31'b0, frame_done}, {31'b0, ((i + 1) % len) == 0});
        end
        dec_valid = 1'b0;
        dec_error = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_y"},   {24'b0, y}, 32'd0);
        check({tag, "_yv"},  {31'b0, y_valid}, 32'd0);
        check({tag, "_fd"},  {31'b0, frame_done}, 32'd0);
        check({tag, "_ec"},  {24'b0, err_count}, 32'd0);
        check({tag, "_lvl"}, {22'b0, level}, 32'd0);
        check({tag, "_ov"},  {31'b0, overflow}, 32'd0);
        check({tag, "_un"},  {31'b0, underflow}, 32'd0);
    endtask

    initial begin
        clr_err();
        #1;
        check_all_zero("reset");
        do_reset();

        // clean 255-symbol frame
        k = 8'd255;
        do_writes(255, 0);
        check("f1_level", {22'b0, level}, 32'd255);
        do_reads(255, 255, "f1");
        check("f1_ec", {24'b0, err_count}, 32'd0);
        check("f1_level0", {22'b0, level}, 32'd0);
        check("f1_ov", {31'b0, overflow}, 32'd0);
        check("f1_un", {31'b0, underflow}, 32'd0);

        // two corrected symbols
        do_writes(255, 0);
        err_tab[3] = 8'h5A;
        err_tab[200] = 8'h01;
        do_reads(255, 255, "f2");
        check("f2_ec", {24'b0, err_count}, 32'd2);
        clr_err();

        // single-symbol frame
        k = 8'd1;
        do_writes(1, 8'h42);
        err_tab[0] = 8'h0F;
        do_reads(1, 1, "k1");
        check("k1_ec", {24'b0, err_count}, 32'd1);
        clr_err();

        // k=0 means 256
        k = 8'd0;
        do_writes(256, 0);
        do_reads(256, 256, "k0");
        check("k0_ec", {24'b0, err_count}, 32'd0);

        // underflow on empty buffer
        dec_valid = 1'b1;
        dec_error = 8'h77;
        tick();
        dec_valid = 1'b0;
        dec_error = 8'h00;
        check("un_y", {24'b0, y}, 32'h77);
        check("un_yv", {31'b0, y_valid}, 32'd1);
        check("un_flag", {31'b0, underflow}, 32'd1);
        check("un_level", {22'b0, level}, 32'd0);
        tick();
        check("un_yv_gap", {31'b0, y_valid}, 32'd0);

        // overflow: 513th symbol dropped
        do_reset();
        k = 8'd255;
        do_writes(512, 0);
        check("ov_level_pre", {22'b0, level}, 32'd512);
        check("ov_flag_pre", {31'b0, overflow}, 32'd0);
        enable = 1'b1;
        x = 8'hEE;
        tick();
        enable = 1'b0;
        check("ov_level", {22'b0, level}, 32'd512);
        check("ov_flag", {31'b0, overflow}, 32'd1);
        do_reads(512, 255, "ov");
        check("ov_level_end", {22'b0, level}, 32'd0);

        // full buffer with simultaneous read and write
        do_reset();
        do_writes(512, 8'h30);
        enable = 1'b1;
        x = 8'hAB;
        dec_valid = 1'b1;
        dec_error = 8'h00;
        tick();
        enable = 1'b0;
        check("sim_y", {24'b0, y}, {24'b0, sym_tab[0]});
        check("sim_level", {22'b0, level}, 32'd512);
        check("sim_ov", {31'b0, overflow}, 32'd0);
        for (int i = 0; i < 512; i++) tick();
        dec_valid = 1'b0;
        check("sim_last_y", {24'b0, y}, 32'hAB);
        check("sim_level_end", {22'b0, level}, 32'd0);

        // reset in the middle of a frame
        do_reset();
        k = 8'd255;
        do_writes(100, 0);
        do_reads(40, 255, "mid");
        clrn = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        clrn = 1'b1;
        k = 8'd16;
        do_writes(16, 8'h10);
        err_tab[5] = 8'hFF;
        do_reads(16, 16, "k16");
        check("k16_ec", {24'b0, err_count}, 32'd1);
        check("k16_level", {22'b0, level}, 32'd0);
        clr_err();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rs_correct_buf.md
Name: rs_correct_buf

Overview:
- Downstream stage of the RS decoder (rsdec).
- Buffers received codeword symbols in arrival order while the decoder computes syndromes, Berlekamp and Chien search.
- When the decoder strobes per-symbol error values, it XORs each error onto the buffered symbol and emits the corrected stream.
- Produces per-frame correction statistics and sticky overflow/underflow flags.

Parameters:
- AW, 9, buffer address width; depth = 2**AW symbols (512 holds two 255-symbol frames).
- DW, 8, symbol width; matches the decoder GF(2^8) symbol.

Ports:
- clk  in  1  clock
- clrn  in  1  asynchronous active-low reset
- enable  in  1  input symbol strobe; the same strobe drives the decoder
- x  in  DW  received symbol; the same bus drives the decoder
- k  in  8  frame length in symbols, 1..255; 0 means 256
- dec_error  in  DW  error value from the decoder for the current symbol
- dec_valid  in  1  decoder valid; one symbol per cycle, in arrival order
- y  out  DW  corrected symbol
- y_valid  out  1  y qualifier
- frame_done  out  1  one-cycle pulse with the last y of a frame
- err_count  out  8  number of nonzero dec_error values in the completed frame; held until the next frame_done
- level  out  AW+1  current buffer occupancy
- overflow  out  1  sticky; a write was attempted while the buffer was full
- underflow  out  1  sticky; dec_valid arrived while the buffer was empty

Behaviour:
- Reset (clrn low, asynchronous): all outputs are 0. Pointers, level, frame index and counters are 0. FSM enters IDLE.
- Reset mid-frame discards all buffered data and statistics immediately.
- Storage:
  - Dual-pointer circular buffer of 2**AW x DW. Write pointer wp and read pointer rp are AW bits wide and wrap modulo depth.
  - level = number of stored symbols, range 0..2**AW.
- Write:
  - On enable with level < depth: buf[wp] <= x, wp++.
  - On enable with level == depth: the symbol is dropped, wp is unchanged, overflow <= 1.
- Read/correct:
  - On dec_valid with level > 0: y <= buf[rp] ^ dec_error, y_valid <= 1 on the next clock (latency 1), rp++.
  - On dec_valid with level == 0: y <= dec_error, y_valid <= 1, underflow <= 1, rp unchanged.
  - y_valid is 0 in every cycle following a cycle without dec_valid.
- Simultaneous enable and dec_valid:
  - Both operations occur in the same cycle; level is unchanged.
  - If level == 0 in that cycle, the read is an underflow. There is no write-through bypass.
  - If level == depth in that cycle, the write succeeds, because the read frees a slot in the same cycle.
- level update: level + (write accepted) - (read from non-empty buffer).
- Frame FSM:
  - IDLE: the first dec_valid latches len <= (k==0 ? 256 : k), sets idx <= 1 and acc <= (dec_error != 0), then moves to FRAME. If len == 1, that same symbol completes the frame.
  - FRAME: each dec_valid does idx++ and acc += (dec_error != 0).
  - Frame completion: when the symbol with idx == len-1 (0-based) is read, the FSM asserts frame_done in the same cycle as that symbol's y_valid, loads err_count <= final acc, clears acc and idx, and returns to IDLE.
  - idx is 9 bits. acc is 9 bits internally; err_count is reported saturated at 255.
- Sticky flags are cleared only by reset.
- k is sampled only at frame start. Changes to k mid-frame take effect for the next frame.
- The buffer never reorders data. The decoder contract is one dec_valid per buffered symbol, in order.

Test Plan:
- Write 255 symbols x = 0..254 with k=255, then 255 dec_valid beats with all dec_error = 0 -> y = 0..254 one cycle after each dec_valid; frame_done with the last y; err_count = 0; flags 0.
- Same frame with dec_error = 0x5A at symbol 3 and 0x01 at symbol 200 -> y[3] = 0x03^0x5A = 0x59, y[200] = 0xC8^0x01 = 0xC9; err_count = 2.
- AW=9: write 512 symbols with no reads, then one more enable -> level = 512, overflow = 1, the 513th symbol is dropped. The next 512 reads return symbols 0..511 in order.
- level = 512, then enable and dec_valid in the same cycle -> write accepted, level stays 512, overflow stays 0.
- Buffer empty, dec_valid with dec_error = 0x77 -> y = 0x77 next cycle, underflow = 1, level stays 0.
- Assert clrn low mid-frame after 100 writes and 40 reads -> all outputs 0 immediately. After release, a fresh k=16 frame corrects and completes with frame_done after 16 reads.
